// File: rtl/hp_tracker_if.sv
// Signal bundle between the game logic and the HP/round controller.
// The master drives the hit, evasion and frame inputs; the slave returns bar edges and flags.
interface hp_tracker_if;
   logic       frame_clk;
   logic       start;
   logic       p1_kick_hit;
   logic       p1_punch_hit;
   logic       p2_kick_hit;
   logic       p2_punch_hit;
   logic       p1_dodge;
   logic       p1_jump;
   logic       p2_dodge;
   logic       p2_jump;
   logic [9:0] hp1x;
   logic [9:0] hp2x;
   logic       p1win;
   logic       p2win;
   logic       p1_hurt;
   logic       p2_hurt;

   modport master (
      output frame_clk, start, p1_kick_hit, p1_punch_hit, p2_kick_hit, p2_punch_hit,
             p1_dodge, p1_jump, p2_dodge, p2_jump,
      input  hp1x, hp2x, p1win, p2win, p1_hurt, p2_hurt
   );

   modport slave (
      input  frame_clk, start, p1_kick_hit, p1_punch_hit, p2_kick_hit, p2_punch_hit,
             p1_dodge, p1_jump, p2_dodge, p2_jump,
      output hp1x, hp2x, p1win, p2win, p1_hurt, p2_hurt
   );
endinterface

// File: rtl/hp_tracker.sv
// Health/round controller: captures hit edges, applies damage once per frame tick,
// tracks invulnerability and the round FSM, and drives the HP-bar edges for the blitter.
module hp_tracker #(
   parameter int unsigned HP_MAX        = 200,
   parameter int unsigned KICK_DMG      = 20,
   parameter int unsigned PUNCH_DMG     = 10,
   parameter int unsigned INVULN_FRAMES = 30,
   parameter int unsigned BAR1_L        = 75,
   parameter int unsigned BAR2_L        = 365
) (
   input logic         i_clk,
   input logic         i_reset_n,
   hp_tracker_if.slave bus
);

   localparam int unsigned IvW = $clog2(INVULN_FRAMES + 1);
   localparam logic [8:0]     HpMax  = 9'(HP_MAX);
   localparam logic [8:0]     KickD  = 9'(KICK_DMG);
   localparam logic [8:0]     PunchD = 9'(PUNCH_DMG);
   localparam logic [IvW-1:0] IvLoad = IvW'(INVULN_FRAMES);

   typedef enum logic [1:0] {StIdle, StFight, StP1Win, StP2Win} state_e;

   state_e         r_state, w_state_d;
   logic [2:0]     r_fs;
   logic [3:0]     r_prev;
   logic [3:0]     r_pend, w_pend_d;
   logic [8:0]     r_hp1, r_hp2, w_hp1_d, w_hp2_d;
   logic [IvW-1:0] r_iv1, r_iv2, w_iv1_d, w_iv2_d;
   logic [3:0]     w_hits, w_rise;
   logic           w_tick;
   logic [8:0]     w_dmg1, w_dmg2;

   // Kick takes precedence over punch when both land unblocked in one frame.
   function automatic logic [8:0] dmg_f(input logic k, input logic p,
                                        input logic jump, input logic dodge);
      if (k && !jump)       return KickD;
      else if (p && !dodge) return PunchD;
      else                  return 9'd0;
   endfunction

   function automatic logic [8:0] sat_sub(input logic [8:0] a, input logic [8:0] b);
      return (a > b) ? (a - b) : 9'd0;
   endfunction

   // Bit order: [0] kick on P2, [1] punch on P2, [2] kick on P1, [3] punch on P1.
   assign w_hits = {bus.p2_punch_hit, bus.p2_kick_hit, bus.p1_punch_hit, bus.p1_kick_hit};
   assign w_rise = w_hits & ~r_prev;
   assign w_tick = r_fs[1] & ~r_fs[2];
   assign w_dmg1 = dmg_f(r_pend[2], r_pend[3], bus.p1_jump, bus.p1_dodge);
   assign w_dmg2 = dmg_f(r_pend[0], r_pend[1], bus.p2_jump, bus.p2_dodge);

   always_comb begin
      w_state_d = r_state;
      w_pend_d  = r_pend;
      w_hp1_d   = r_hp1;
      w_hp2_d   = r_hp2;
      w_iv1_d   = r_iv1;
      w_iv2_d   = r_iv2;
      unique case (r_state)
         StIdle: begin
            w_pend_d = '0;
            w_hp1_d  = HpMax;
            w_hp2_d  = HpMax;
            w_iv1_d  = '0;
            w_iv2_d  = '0;
            if (bus.start) w_state_d = StFight;
         end
         StFight: begin
            w_pend_d = w_rise | (r_pend & {4{~w_tick}});
            if (w_tick) begin
               if (r_iv1 != '0) begin
                  w_iv1_d = r_iv1 - IvW'(1);
               end else if (w_dmg1 != 9'd0) begin
                  w_hp1_d = sat_sub(r_hp1, w_dmg1);
                  w_iv1_d = IvLoad;
               end
               if (r_iv2 != '0) begin
                  w_iv2_d = r_iv2 - IvW'(1);
               end else if (w_dmg2 != 9'd0) begin
                  w_hp2_d = sat_sub(r_hp2, w_dmg2);
                  w_iv2_d = IvLoad;
               end
            end
            // P2 knocked out is checked first so a double KO goes to P1.
            if (r_hp2 == 9'd0)      w_state_d = StP1Win;
            else if (r_hp1 == 9'd0) w_state_d = StP2Win;
         end
         StP1Win, StP2Win: begin
            w_pend_d = '0;
         end
         default: w_state_d = StIdle;
      endcase
      if (!bus.start) begin
         w_state_d = StIdle;
         w_pend_d  = '0;
         w_hp1_d   = HpMax;
         w_hp2_d   = HpMax;
         w_iv1_d   = '0;
         w_iv2_d   = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
         r_fs    <= '0;
         r_prev  <= '0;
         r_pend  <= '0;
         r_hp1   <= HpMax;
         r_hp2   <= HpMax;
         r_iv1   <= '0;
         r_iv2   <= '0;
      end else begin
         r_state <= w_state_d;
         r_fs    <= {r_fs[1:0], bus.frame_clk};
         r_prev  <= w_hits;
         r_pend  <= w_pend_d;
         r_hp1   <= w_hp1_d;
         r_hp2   <= w_hp2_d;
         r_iv1   <= w_iv1_d;
         r_iv2   <= w_iv2_d;
      end
   end

   assign bus.hp1x    = 10'(BAR1_L + HP_MAX) - 10'(r_hp1);
   assign bus.hp2x    = 10'(BAR2_L) + 10'(r_hp2) - 10'd1;
   assign bus.p1win   = (r_state == StP1Win);
   assign bus.p2win   = (r_state == StP2Win);
   assign bus.p1_hurt = (r_iv1 != '0);
   assign bus.p2_hurt = (r_iv2 != '0);

endmodule

// File: tb/tb_hp_tracker.sv
// Directed bench for hp_tracker: reset/idle, damage, invulnerability, blocking,
// saturation, KO priority, restart and mid-round reset.
module tb_hp_tracker;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   hp_tracker_if bus ();

   hp_tracker dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic frame();
      @(negedge clk) bus.frame_clk = 1'b1;
      repeat (3) @(negedge clk);
      bus.frame_clk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   // Mask order: {p2_punch, p2_kick, p1_punch, p1_kick}.
   task automatic pulse(input logic [3:0] m);
      @(negedge clk);
      {bus.p2_punch_hit, bus.p2_kick_hit, bus.p1_punch_hit, bus.p1_kick_hit} = m;
      @(negedge clk);
      {bus.p2_punch_hit, bus.p2_kick_hit, bus.p1_punch_hit, bus.p1_kick_hit} = 4'b0000;
   endtask

   // Land a hit, then wait out the full invulnerability window.
   task automatic land(input logic [3:0] m);
      pulse(m);
      frame();
      frames(30);
   endtask

   initial begin
      reset_n = 1'b0;
      bus.frame_clk = 1'b0;  bus.start = 1'b0;
      bus.p1_kick_hit = 1'b0; bus.p1_punch_hit = 1'b0;
      bus.p2_kick_hit = 1'b0; bus.p2_punch_hit = 1'b0;
      bus.p1_dodge = 1'b0; bus.p1_jump = 1'b0; bus.p2_dodge = 1'b0; bus.p2_jump = 1'b0;

      // Reset and idle with hits toggling
      repeat (2) @(negedge clk);
      check("rst_hp1x", 32'(bus.hp1x), 75);
      check("rst_hp2x", 32'(bus.hp2x), 564);
      check("rst_wins", 32'({bus.p1win, bus.p2win}), 0);
      check("rst_hurt", 32'({bus.p1_hurt, bus.p2_hurt}), 0);
      reset_n = 1'b1;
      pulse(4'b1111); frame();
      pulse(4'b0101); frame();
      check("idle_hp1x", 32'(bus.hp1x), 75);
      check("idle_hp2x", 32'(bus.hp2x), 564);
      check("idle_flags", 32'({bus.p1win, bus.p2win, bus.p1_hurt, bus.p2_hurt}), 0);

      // Single kick, exact tick latency, invulnerability window
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk);
      frame();
      check("start_nodmg_hp2x", 32'(bus.hp2x), 564);
      pulse(4'b0001);
      @(negedge clk) bus.frame_clk = 1'b1;
      repeat (2) @(negedge clk);
      check("kick_early_hp2x", 32'(bus.hp2x), 564);
      @(negedge clk);
      check("kick_hp2x", 32'(bus.hp2x), 544);
      check("kick_p2_hurt", 32'(bus.p2_hurt), 1);
      bus.frame_clk = 1'b0;
      repeat (2) @(negedge clk);
      pulse(4'b0001); frame();
      check("invuln_kick_hp2x", 32'(bus.hp2x), 544);
      frames(28);
      check("invuln_last_hurt", 32'(bus.p2_hurt), 1);
      frame();
      check("invuln_end_hurt", 32'(bus.p2_hurt), 0);
      check("invuln_end_hp2x", 32'(bus.hp2x), 544);

      // Held punch counts once; dodge blocks and still clears the pending bit
      @(negedge clk) bus.p2_punch_hit = 1'b1;
      frames(5);
      bus.p2_punch_hit = 1'b0;
      check("held_hp1x", 32'(bus.hp1x), 85);
      check("held_p1_hurt", 32'(bus.p1_hurt), 1);
      frames(26);
      check("held_hurt_done", 32'(bus.p1_hurt), 0);
      bus.p1_dodge = 1'b1;
      pulse(4'b1000); frame();
      check("dodge_hp1x", 32'(bus.hp1x), 85);
      bus.p1_dodge = 1'b0;
      frame();
      check("dodge_clear_hp1x", 32'(bus.hp1x), 85);
      check("dodge_p1_hurt", 32'(bus.p1_hurt), 0);

      // Kick+punch together, then drive P2 down and saturate
      land(4'b0011);
      check("kp_hp2x", 32'(bus.hp2x), 524);
      for (int i = 0; i < 7; i++) land(4'b0001);
      land(4'b0010);
      check("ten_hp2x", 32'(bus.hp2x), 374);
      pulse(4'b0001);
      @(negedge clk) bus.frame_clk = 1'b1;
      repeat (3) @(negedge clk);
      check("sat_hp2x", 32'(bus.hp2x), 364);
      check("sat_p1win_early", 32'(bus.p1win), 0);
      @(negedge clk);
      check("sat_p1win", 32'(bus.p1win), 1);
      check("sat_p2win", 32'(bus.p2win), 0);
      bus.frame_clk = 1'b0;
      repeat (2) @(negedge clk);
      pulse(4'b0100); frame();
      check("frozen_hp1x", 32'(bus.hp1x), 85);

      // Restart clears hp, invuln and win flag in one cycle
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk);
      check("restart_hp1x", 32'(bus.hp1x), 75);
      check("restart_hp2x", 32'(bus.hp2x), 564);
      check("restart_p1win", 32'(bus.p1win), 0);
      check("restart_hurt", 32'({bus.p1_hurt, bus.p2_hurt}), 0);

      // Simultaneous KO goes to P1
      bus.start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 9; i++) land(4'b0101);
      land(4'b1010);
      check("ko_pre_hp1x", 32'(bus.hp1x), 265);
      check("ko_pre_hp2x", 32'(bus.hp2x), 374);
      pulse(4'b1010);
      @(negedge clk) bus.frame_clk = 1'b1;
      repeat (3) @(negedge clk);
      check("ko_hp1x", 32'(bus.hp1x), 275);
      check("ko_hp2x", 32'(bus.hp2x), 364);
      @(negedge clk);
      check("ko_wins", 32'({bus.p1win, bus.p2win}), 32'b10);
      bus.frame_clk = 1'b0;
      repeat (2) @(negedge clk);

      // P2 win, then drop start
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) land(4'b0100);
      check("p2w_hp1x", 32'(bus.hp1x), 275);
      check("p2w_hp2x", 32'(bus.hp2x), 564);
      check("p2w_wins", 32'({bus.p1win, bus.p2win}), 32'b01);
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk);
      check("p2w_idle_wins", 32'({bus.p1win, bus.p2win}), 0);
      check("p2w_idle_hp1x", 32'(bus.hp1x), 75);

      // Reset during a fight with a hit pending
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      pulse(4'b0001);
      @(negedge clk) reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_hp2x", 32'(bus.hp2x), 564);
      check("midrst_flags", 32'({bus.p1win, bus.p2win, bus.p1_hurt, bus.p2_hurt}), 0);
      reset_n = 1'b1;
      @(negedge clk);
      frame();
      check("midrst_nodmg_hp2x", 32'(bus.hp2x), 564);
      check("midrst_nodmg_hurt", 32'(bus.p2_hurt), 0);
      pulse(4'b0001); frame();
      check("post_rst_kick_hp2x", 32'(bus.hp2x), 544);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
